// File: rtl/weight_scheduler.sv
// Ping-pong weight bank scheduler: walks the weight loader and conv engine over a layer's
// filters in order, prefetching the next filter into the free bank while the other is consumed.
module weight_scheduler #(
   parameter int IDX_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             layer_start,
   input  logic [IDX_W-1:0] out_ch,
   output logic             busy,
   output logic             layer_done,
   output logic             ld_start,
   input  logic             ld_done,
   output logic [IDX_W-1:0] ld_weight_idx,
   output logic             ld_bank,
   output logic             conv_start,
   input  logic             conv_done,
   output logic             conv_bank,
   output logic [IDX_W-1:0] conv_weight_idx
);

   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic [1:0] {L_IDLE, L_ISSUE, L_WAIT} ld_state_t;
   typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_RUN} cv_state_t;

   ld_state_t        ld_state_q;
   cv_state_t        cv_state_q;
   logic [1:0]       bank_full_q;
   logic [1:0]       bank_full_d;
   logic             ld_ptr_q;
   logic             cv_ptr_q;
   logic [IDX_W-1:0] ld_cnt_q;
   logic [IDX_W-1:0] cv_cnt_q;
   logic [IDX_W-1:0] out_ch_q;
   logic             busy_q;
   logic             layer_done_q;
   logic             ld_start_q;
   logic [IDX_W-1:0] ld_idx_q;
   logic             ld_bank_q;
   logic             conv_start_q;
   logic             conv_bank_q;
   logic [IDX_W-1:0] conv_idx_q;

   logic accept;
   logic ld_fire;
   logic cv_fire;
   logic last_filter;

   assign accept      = layer_start & ~busy_q;
   assign ld_fire     = (ld_state_q == L_WAIT) & ld_done;
   assign cv_fire     = (cv_state_q == C_RUN) & conv_done;
   assign last_filter = (cv_cnt_q + IDX_ONE) == out_ch_q;

   // Loader and conv always target different banks, so a same-cycle set and clear never collide.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_full_d[gi] = accept                          ? 1'b0 :
                               (cv_fire && cv_ptr_q == 1'(gi)) ? 1'b0 :
                               (ld_fire && ld_ptr_q == 1'(gi)) ? 1'b1 :
                                                                 bank_full_q[gi];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_full_q <= 2'b00;
      end else begin
         bank_full_q <= bank_full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_state_q <= L_IDLE;
         ld_ptr_q   <= 1'b0;
         ld_cnt_q   <= '0;
         ld_start_q <= 1'b0;
         ld_idx_q   <= '0;
         ld_bank_q  <= 1'b0;
      end else begin
         ld_start_q <= 1'b0;
         if (accept) begin
            ld_state_q <= L_IDLE;
            ld_ptr_q   <= 1'b0;
            ld_cnt_q   <= '0;
         end else begin
            case (ld_state_q)
               L_IDLE: begin
                  if (busy_q && ld_cnt_q != out_ch_q && !bank_full_q[ld_ptr_q]) begin
                     ld_state_q <= L_ISSUE;
                  end
               end
               L_ISSUE: begin
                  ld_start_q <= 1'b1;
                  ld_idx_q   <= ld_cnt_q;
                  ld_bank_q  <= ld_ptr_q;
                  ld_state_q <= L_WAIT;
               end
               L_WAIT: begin
                  if (ld_done) begin
                     ld_ptr_q   <= ~ld_ptr_q;
                     ld_cnt_q   <= ld_cnt_q + IDX_ONE;
                     ld_state_q <= L_IDLE;
                  end
               end
               default: ld_state_q <= L_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cv_state_q   <= C_IDLE;
         cv_ptr_q     <= 1'b0;
         cv_cnt_q     <= '0;
         out_ch_q     <= '0;
         busy_q       <= 1'b0;
         layer_done_q <= 1'b0;
         conv_start_q <= 1'b0;
         conv_bank_q  <= 1'b0;
         conv_idx_q   <= '0;
      end else begin
         conv_start_q <= 1'b0;
         layer_done_q <= 1'b0;
         if (accept) begin
            busy_q     <= 1'b1;
            out_ch_q   <= out_ch;
            cv_ptr_q   <= 1'b0;
            cv_cnt_q   <= '0;
            cv_state_q <= C_IDLE;
         end else begin
            // An empty layer finishes on its own one cycle after acceptance.
            if (busy_q && out_ch_q == '0) begin
               busy_q       <= 1'b0;
               layer_done_q <= 1'b1;
            end
            case (cv_state_q)
               C_IDLE: begin
                  if (busy_q && bank_full_q[cv_ptr_q]) begin
                     cv_state_q <= C_ISSUE;
                  end
               end
               C_ISSUE: begin
                  conv_start_q <= 1'b1;
                  conv_bank_q  <= cv_ptr_q;
                  conv_idx_q   <= cv_cnt_q;
                  cv_state_q   <= C_RUN;
               end
               C_RUN: begin
                  if (conv_done) begin
                     cv_ptr_q   <= ~cv_ptr_q;
                     cv_cnt_q   <= cv_cnt_q + IDX_ONE;
                     cv_state_q <= C_IDLE;
                     if (last_filter) begin
                        layer_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                     end
                  end
               end
               default: cv_state_q <= C_IDLE;
            endcase
         end
      end
   end

   assign busy            = busy_q;
   assign layer_done      = layer_done_q;
   assign ld_start        = ld_start_q;
   assign ld_weight_idx   = ld_idx_q;
   assign ld_bank         = ld_bank_q;
   assign conv_start      = conv_start_q;
   assign conv_bank       = conv_bank_q;
   assign conv_weight_idx = conv_idx_q;

endmodule

// File: tb/tb_weight_scheduler.sv
// Bench for weight_scheduler: latency-programmable loader/conv responders plus an event-time
// model predicting every start pulse, index, bank, busy and layer_done from the handshake times.
module tb_weight_scheduler;

   localparam int IDX_W = 9;
   localparam int MAXF  = 16;
   localparam int INF   = 32'h3fff_ffff;

   logic             clk;
   logic             rst;
   logic             layer_start;
   logic [IDX_W-1:0] out_ch;
   logic             busy, layer_done, ld_start, ld_bank, conv_start, conv_bank;
   logic [IDX_W-1:0] ld_weight_idx, conv_weight_idx;
   logic             ld_done_r, conv_done_r, spur_ld, spur_cv;
   logic             ld_done_w, conv_done_w;

   assign ld_done_w   = ld_done_r | spur_ld;
   assign conv_done_w = conv_done_r | spur_cv;

   weight_scheduler #(.IDX_W(IDX_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .layer_start     (layer_start),
      .out_ch          (out_ch),
      .busy            (busy),
      .layer_done      (layer_done),
      .ld_start        (ld_start),
      .ld_done         (ld_done_w),
      .ld_weight_idx   (ld_weight_idx),
      .ld_bank         (ld_bank),
      .conv_start      (conv_start),
      .conv_done       (conv_done_w),
      .conv_bank       (conv_bank),
      .conv_weight_idx (conv_weight_idx)
   );

   int cyc;
   int n_cmp, n_err;

   // Reference model state: layer acceptance edge plus sampled handshake edges per filter.
   int  t_acc, m_n, m_nls, m_ncs;
   bit  m_active, mon_en;
   int  t_ld_done[MAXF];
   int  t_cv_done[MAXF];
   bit  ldv[MAXF];
   bit  cdv[MAXF];
   int  nld, ncd, gen;
   int  ld_lat, cv_lat;
   bit  rnd_lat;
   bit  ld_fl, cv_fl;
   int  ld_k, cv_k;

   typedef struct {
      int n;
      int ll;
      int cl;
      bit rnd;
      bit poke;
      int dur;
   } vec_t;
   vec_t vecs[7];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Load k may start two edges after load k-1 finished and the bank it reuses (conv k-2) was freed.
   function automatic int exp_ls(input int k);
      int t;
      if (k >= MAXF) return INF;
      if (k == 0) return t_acc + 2;
      if (!ldv[k-1]) return INF;
      t = t_ld_done[k-1];
      if (k >= 2) begin
         if (!cdv[k-2]) return INF;
         t = imax(t, t_cv_done[k-2]);
      end
      return t + 2;
   endfunction

   // Conv k may start two edges after its own load landed and conv k-1 released the engine.
   function automatic int exp_cs(input int k);
      int t;
      if (k >= MAXF || !ldv[k]) return INF;
      t = t_ld_done[k];
      if (k >= 1) begin
         if (!cdv[k-1]) return INF;
         t = imax(t, t_cv_done[k-1]);
      end
      return t + 2;
   endfunction

   function automatic int exp_done();
      if (m_n == 0) return t_acc + 1;
      if (m_n > MAXF || !cdv[m_n-1]) return INF;
      return t_cv_done[m_n-1];
   endfunction

   // Per-cycle monitor
   initial begin
      bit e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            e = m_active && (m_nls < m_n) && (cyc == exp_ls(m_nls));
            chk("ld_start", int'(ld_start), int'(e));
            if (e) begin
               chk("ld_weight_idx", int'(ld_weight_idx), m_nls);
               chk("ld_bank", int'(ld_bank), m_nls % 2);
               ld_fl = 1'b1;
               ld_k  = m_nls;
               m_nls++;
            end else if (ld_fl) begin
               if (ldv[ld_k] && cyc >= t_ld_done[ld_k]) ld_fl = 1'b0;
               else begin
                  chk("ld_idx_hold", int'(ld_weight_idx), ld_k);
                  chk("ld_bank_hold", int'(ld_bank), ld_k % 2);
               end
            end

            e = m_active && (m_ncs < m_n) && (cyc == exp_cs(m_ncs));
            chk("conv_start", int'(conv_start), int'(e));
            if (e) begin
               chk("conv_weight_idx", int'(conv_weight_idx), m_ncs);
               chk("conv_bank", int'(conv_bank), m_ncs % 2);
               cv_fl = 1'b1;
               cv_k  = m_ncs;
               m_ncs++;
            end else if (cv_fl) begin
               if (cdv[cv_k] && cyc >= t_cv_done[cv_k]) cv_fl = 1'b0;
               else begin
                  chk("conv_idx_hold", int'(conv_weight_idx), cv_k);
                  chk("conv_bank_hold", int'(conv_bank), cv_k % 2);
               end
            end

            e = m_active && (cyc == exp_done());
            chk("layer_done", int'(layer_done), int'(e));
            chk("busy", int'(busy), int'(m_active && cyc >= t_acc && !e));
            if (e) m_active = 1'b0;
         end
      end
   end

   // Weight loader responder
   initial begin
      int lat, g, k;
      ld_done_r = 1'b0;
      forever begin
         @(negedge clk);
         if (ld_start) begin
            g   = gen;
            k   = nld;
            lat = rnd_lat ? int'($urandom_range(1, 10)) : ld_lat;
            for (int w = 1; w < lat && g == gen; w++) @(negedge clk);
            if (g == gen && k < MAXF) begin
               ld_done_r    = 1'b1;
               t_ld_done[k] = cyc + 1;
               ldv[k]       = 1'b1;
               nld          = k + 1;
               @(negedge clk);
               ld_done_r = 1'b0;
            end
         end
      end
   end

   // Conv engine responder
   initial begin
      int lat, g, k;
      conv_done_r = 1'b0;
      forever begin
         @(negedge clk);
         if (conv_start) begin
            g   = gen;
            k   = ncd;
            lat = rnd_lat ? int'($urandom_range(1, 10)) : cv_lat;
            for (int w = 1; w < lat && g == gen; w++) @(negedge clk);
            if (g == gen && k < MAXF) begin
               conv_done_r  = 1'b1;
               t_cv_done[k] = cyc + 1;
               cdv[k]       = 1'b1;
               ncd          = k + 1;
               @(negedge clk);
               conv_done_r = 1'b0;
            end
         end
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_layer_done"}, int'(layer_done), 0);
      chk({tag, "_ld_start"}, int'(ld_start), 0);
      chk({tag, "_ld_weight_idx"}, int'(ld_weight_idx), 0);
      chk({tag, "_ld_bank"}, int'(ld_bank), 0);
      chk({tag, "_conv_start"}, int'(conv_start), 0);
      chk({tag, "_conv_bank"}, int'(conv_bank), 0);
      chk({tag, "_conv_weight_idx"}, int'(conv_weight_idx), 0);
   endtask

   task automatic start_layer(input int n, input int ll, input int cl, input bit rnd);
      ld_lat  = ll;
      cv_lat  = cl;
      rnd_lat = rnd;
      @(negedge clk);
      for (int i = 0; i < MAXF; i++) begin
         ldv[i] = 1'b0;
         cdv[i] = 1'b0;
      end
      nld         = 0;
      ncd         = 0;
      layer_start = 1'b1;
      out_ch      = IDX_W'(n);
      t_acc       = cyc + 1;
      m_n         = n;
      m_nls       = 0;
      m_ncs       = 0;
      m_active    = 1'b1;
      @(negedge clk);
      layer_start = 1'b0;
      out_ch      = IDX_W'($urandom_range(0, 511));
   endtask

   task automatic finish_layer(input bit poke, input int exp_dur);
      bit done;
      int t_done;
      done   = 1'b0;
      t_done = 0;
      for (int w = 0; w < 3000 && !done; w++) begin
         @(negedge clk);
         layer_start = poke && (w == 10);
         if (poke && w == 10) out_ch = IDX_W'(7);
         if (layer_done) begin
            done   = 1'b1;
            t_done = cyc;
         end
      end
      layer_start = 1'b0;
      chk("layer_done_seen", int'(done), 1);
      if (done && exp_dur >= 0) chk("layer_duration", t_done - t_acc, exp_dur);
      repeat (3) @(negedge clk);
      chk("load_count", nld, m_n);
      chk("conv_count", ncd, m_n);
      $display("layer out_ch=%0d accepted@%0d done@%0d loads=%0d convs=%0d",
               m_n, t_acc, t_done, nld, ncd);
   endtask

   initial begin
      int w;
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      layer_start = 1'b0;
      out_ch      = '0;
      spur_ld     = 1'b0;
      spur_cv     = 1'b0;
      mon_en      = 1'b0;
      m_active    = 1'b0;
      m_n         = 0;
      t_acc       = 0;
      gen         = 0;
      nld         = 0;
      ncd         = 0;
      ld_fl       = 1'b0;
      cv_fl       = 1'b0;
      rnd_lat     = 1'b0;
      ld_lat      = 1;
      cv_lat      = 1;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst    = 1'b0;
      mon_en = 1'b1;

      // Durations are accept-edge to layer_done-edge, worked out by hand from the timing rules.
      vecs[0] = '{n: 0, ll: 1,  cl: 1,  rnd: 1'b0, poke: 1'b0, dur: 1};
      vecs[1] = '{n: 1, ll: 20, cl: 50, rnd: 1'b0, poke: 1'b0, dur: 74};
      vecs[2] = '{n: 4, ll: 5,  cl: 40, rnd: 1'b0, poke: 1'b1, dur: 175};
      vecs[3] = '{n: 3, ll: 40, cl: 3,  rnd: 1'b0, poke: 1'b0, dur: 131};
      vecs[4] = '{n: 4, ll: 5,  cl: 5,  rnd: 1'b0, poke: 1'b0, dur: 35};
      vecs[5] = '{n: 2, ll: 1,  cl: 1,  rnd: 1'b0, poke: 1'b0, dur: 9};
      vecs[6] = '{n: 0, ll: 1,  cl: 1,  rnd: 1'b0, poke: 1'b0, dur: 1};
      for (int i = 0; i < 7; i++) begin
         start_layer(vecs[i].n, vecs[i].ll, vecs[i].cl, vecs[i].rnd);
         finish_layer(vecs[i].poke, vecs[i].dur);
      end

      for (int i = 0; i < 8; i++) begin
         start_layer(int'($urandom_range(0, 9)), 1, 1, 1'b1);
         finish_layer(1'b0, -1);
      end

      // Stray handshakes while idle must not start anything.
      @(negedge clk);
      spur_ld = 1'b1;
      @(negedge clk);
      spur_ld = 1'b0;
      spur_cv = 1'b1;
      @(negedge clk);
      spur_cv = 1'b0;
      repeat (3) @(negedge clk);
      chk("spurious_busy", int'(busy), 0);

      // Reset in the middle of a 5-filter layer, then a clean 2-filter layer.
      start_layer(5, 4, 6, 1'b0);
      w = 0;
      while (ncd < 2 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("reset_setup_two_convs", int'(ncd >= 2), 1);
      mon_en = 1'b0;
      rst    = 1'b1;
      gen++;
      @(negedge clk);
      check_idle("mid_rst");
      rst      = 1'b0;
      m_active = 1'b0;
      ld_fl    = 1'b0;
      cv_fl    = 1'b0;
      mon_en   = 1'b1;
      repeat (15) @(negedge clk);
      start_layer(2, 3, 3, 1'b0);
      finish_layer(1'b0, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/weight_scheduler.md
# weight_scheduler

Sequences the weight loader across all output-channel filters of a layer, ping-ponging between two weight SRAM banks so the next filter is prefetched from DRAM while the conv engine consumes the current one. Sits between the layer controller (layer_start/layer_done) and the weight loader / conv engine handshakes. Holds no weight data; it owns only bank-occupancy state, filter counters and start pulses.

## Interface
- IDX_W, 9, width of filter index and out_ch count
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- layer_start  in  1  one-cycle pulse; accepted only when busy=0
- out_ch  in  IDX_W  filters in the layer; sampled with accepted layer_start
- busy  out  1  high from accepted layer_start until layer_done
- layer_done  out  1  one-cycle pulse when last filter's conv_done observed
- ld_start  out  1  one-cycle pulse to weight loader ap_start
- ld_done  in  1  weight loader ap_done pulse
- ld_weight_idx  out  IDX_W  filter index for loader; stable from ld_start until ld_done
- ld_bank  out  1  SRAM bank the loader writes; stable from ld_start until ld_done
- conv_start  out  1  one-cycle pulse: bank conv_bank holds filter conv_weight_idx
- conv_done  in  1  one-cycle pulse: conv engine released conv_bank
- conv_bank  out  1  bank conv engine reads; stable from conv_start until conv_done
- conv_weight_idx  out  IDX_W  filter index in conv_bank

## Operation
- State: bank_full[1:0], ld_ptr, cv_ptr (bank pointers), ld_cnt, cv_cnt (IDX_W bits), latched out_ch_r.
- Loader FSM: L_IDLE, L_ISSUE, L_WAIT.
  - L_IDLE: if busy and ld_cnt<out_ch_r and bank_full[ld_ptr]=0 -> L_ISSUE.
  - L_ISSUE: ld_start=1 one cycle, ld_weight_idx=ld_cnt, ld_bank=ld_ptr -> L_WAIT.
  - L_WAIT: on ld_done set bank_full[ld_ptr], toggle ld_ptr, ld_cnt+1 -> L_IDLE.
- Conv FSM: C_IDLE, C_ISSUE, C_RUN.
  - C_IDLE: if busy and bank_full[cv_ptr]=1 -> C_ISSUE.
  - C_ISSUE: conv_start=1 one cycle, conv_bank=cv_ptr, conv_weight_idx=cv_cnt -> C_RUN.
  - C_RUN: on conv_done clear bank_full[cv_ptr], toggle cv_ptr, cv_cnt+1; if cv_cnt+1==out_ch_r pulse layer_done, clear busy -> C_IDLE.
- layer_start accepted when busy=0: latch out_ch, zero counters, pointers, bank_full; busy=1. Ignored while busy=1.
- out_ch=0: no ld_start/conv_start; layer_done pulses the cycle after acceptance; busy high exactly one cycle.
- ld_done outside L_WAIT and conv_done outside C_RUN ignored.
- Same-cycle ld_done (sets bank X) and conv_done (clears bank Y): both apply; X≠Y guaranteed by full-flag gating.
- Both banks full: loader stays in L_IDLE until conv_done frees a bank.
- Filter order strictly 0..out_ch-1 on both sides; conv never precedes its load.
- Counters compare with equality only; no wrap (max out_ch 2^IDX_W-1).

## Timing
- All outputs registered. Reset values: busy=0, layer_done=0, ld_start=0, ld_weight_idx=0, ld_bank=0, conv_start=0, conv_bank=0, conv_weight_idx=0.
- layer_start at edge N -> L_ISSUE at N+1 -> ld_start high for cycle after edge N+2.
- ld_done at edge K -> conv_start (if conv idle on that bank) high after edge K+2; next ld_start (if other bank empty) high after edge K+2.
- conv_done at edge M -> next conv_start high after edge M+2 if next bank already full; layer_done high after edge M for last filter.
- rst asserted any cycle: all FSMs to idle, all state and outputs to reset values at that edge; in-flight loader/conv handshakes abandoned (those blocks reset on same rst).

## Test plan
- out_ch=0, layer_start -> layer_done after 1 cycle, no ld_start/conv_start, busy one cycle.
- out_ch=1, ld_done 20 cycles after ld_start, conv_done 50 cycles after conv_start -> one load (idx0, bank0), one conv (idx0, bank0), layer_done with conv_done.
- out_ch=4, fast loader (5 cycles), slow conv (40) -> loads 0,1 fill both banks, load 2 waits for first conv_done, banks alternate 0,1,0,1, layer_done after 4th conv_done.
- out_ch=3, slow loader (40), fast conv (3) -> conv_start exactly 2 cycles after each ld_done, conv indices 0,1,2.
- ld_done and conv_done in the same cycle -> one bank set and other cleared; no lost or duplicated filter; spurious ld_done/conv_done while idle ignored; second layer_start while busy ignored.
- rst mid-layer (after 2 of 5 filters) -> all outputs zero next cycle; fresh layer_start with out_ch=2 completes normally from idx 0.
